alu_op_sequencer: RTL and testbench

//  Issue-side controller for the 4-bit shift/add/sub ALU. Accepts commands over a

---
 rtl/alu_op_sequencer.sv | 108 ++++++++++
 tb/tb_alu_op_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue-side controller for the 4-bit shift/add/sub ALU: register file, operand issue, writeback, response port.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds the registered rsp_zero output.
module alu_op_sequencer #(
   parameter int DW   = 4,
   parameter int NREG = 4,
   parameter int SW   = 2,
   localparam int IW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_ld,
   input  logic [1:0]    cmd_op,
   input  logic [IW-1:0] cmd_rd,
   input  logic [IW-1:0] cmd_rs,
   input  logic [IW-1:0] cmd_rt,
   input  logic [DW-1:0] cmd_imm,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [SW-1:0] alu_c,
   output logic [1:0]    alu_op,
   input  logic [DW-1:0] alu_ans,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [IW-1:0] rsp_rd,
   output logic [DW-1:0] rsp_data,
`ifdef ALU_SEQ_ZERO_FLAG_EN
   output logic          rsp_zero,
`endif
   output logic [1:0]    dbgState
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   logic [DW-1:0] regFile [NREG];
   logic [IW-1:0] pendRd;

   // Both ports: a transfer happens on a rising edge where valid && ready; the
   // producer holds its payload stable until that edge, and ready never waits on valid.
   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign dbgState  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         for (int i = 0; i < NREG; i++) regFile[i] <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_c    <= '0;
         alu_op   <= '0;
         pendRd   <= '0;
         rsp_rd   <= '0;
         rsp_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_ld) begin
                     regFile[cmd_rd] <= cmd_imm;
                     rsp_data        <= cmd_imm;
                     rsp_rd          <= cmd_rd;
                     state           <= RESP;
                  end else begin
                     // Operands come from the register file as it stands at accept.
                     alu_a  <= regFile[cmd_rs];
                     alu_b  <= regFile[cmd_rt];
                     alu_c  <= SW'(cmd_rt);
                     alu_op <= cmd_op;
                     pendRd <= cmd_rd;
                     state  <= EXEC;
                  end
               end
            end
            EXEC: begin
               regFile[pendRd] <= alu_ans;
               rsp_data        <= alu_ans;
               rsp_rd          <= pendRd;
               state           <= RESP;
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_ZERO_FLAG_EN
   // Tracks rsp_data: loaded on exactly the same edges with the zero test of the same value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_zero <= 1'b0;
      end else if (state == IDLE && cmd_valid && cmd_ld) begin
         rsp_zero <= (cmd_imm == '0);
      end else if (state == EXEC) begin
         rsp_zero <= (alu_ans == '0);
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the external ALU.
module tb_alu_op_sequencer;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_ld = 1'b0;
   logic [1:0]    cmd_op = '0;
   logic [1:0]    cmd_rd = '0;
   logic [1:0]    cmd_rs = '0;
   logic [1:0]    cmd_rt = '0;
   logic [DW-1:0] cmd_imm = '0;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [1:0]    alu_c;
   logic [1:0]    alu_op;
   logic [DW-1:0] alu_ans;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [1:0]    rsp_rd;
   logic [DW-1:0] rsp_data;
   logic [1:0]    dbgState;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic          rsp_zero;
`endif

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] expQ [$];

   // clock / reset
   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_op(alu_op), .alu_ans(alu_ans),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
`ifdef ALU_SEQ_ZERO_FLAG_EN
      .rsp_zero(rsp_zero),
`endif
      .dbgState(dbgState)
   );

   // external ALU: 00 sra, 01 srl, 10 sub, 11 add
   logic signed [DW-1:0] aSigned;
   always_comb begin
      aSigned = alu_a;
      case (alu_op)
         2'b00:   alu_ans = aSigned >>> alu_c;
         2'b01:   alu_ans = alu_a >> alu_c;
         2'b10:   alu_ans = alu_a - alu_b;
         default: alu_ans = alu_a + alu_b;
      endcase
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver: presents one command and returns #1 after the accepting edge
   task automatic sendCmd(input int ld, input int op, input int rd, input int rs, input int rt, input int imm);
      int n;
      @(negedge clk);
      cmd_ld    = 1'(ld);
      cmd_op    = 2'(op);
      cmd_rd    = 2'(rd);
      cmd_rs    = 2'(rs);
      cmd_rt    = 2'(rt);
      cmd_imm   = 4'(imm);
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkVal("cmd_ready_at_send", 32'(cmd_ready), 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // waits for rsp_valid counting edges since accept, then checks against the queue head
   task automatic waitRsp(input string tag, input int expRd, input int expLat);
      int lat;
      logic [DW-1:0] expData;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkVal({tag, "_latency"}, 32'(lat), 32'(expLat));
      expData = (expQ.size() > 0) ? expQ.pop_front() : '0;
      checkVal({tag, "_rd"}, 32'(rsp_rd), 32'(expRd));
      checkVal({tag, "_data"}, 32'(rsp_data), 32'(expData));
`ifdef ALU_SEQ_ZERO_FLAG_EN
      checkVal({tag, "_zero"}, 32'(rsp_zero), (expData == '0) ? 1 : 0);
`endif
   endtask

   task automatic consumeRsp(input string tag);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checkVal({tag, "_valid_drop"}, 32'(rsp_valid), 0);
   endtask

   task automatic doLoad(input string tag, input int rd, input int imm);
      expQ.push_back(4'(imm));
      sendCmd(1, 0, rd, 0, 0, imm);
      waitRsp(tag, rd, 1);
      consumeRsp(tag);
   endtask

   task automatic doAlu(input string tag, input int op, input int rd, input int rs, input int rt, input int exp);
      expQ.push_back(4'(exp));
      sendCmd(0, op, rd, rs, rt, 0);
      waitRsp(tag, rd, 2);
      consumeRsp(tag);
   endtask

   // srl by 0 into the same register reads a value back without changing it
   task automatic readReg(input string tag, input int r, input int exp);
      doAlu(tag, 1, r, r, 0, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset values
      #12;
      checkVal("rst_rsp_valid", 32'(rsp_valid), 0);
      checkVal("rst_cmd_ready", 32'(cmd_ready), 1);
      checkVal("rst_alu_a", 32'(alu_a), 0);
      checkVal("rst_alu_b", 32'(alu_b), 0);
      checkVal("rst_alu_c", 32'(alu_c), 0);
      checkVal("rst_alu_op", 32'(alu_op), 0);
      checkVal("rst_rsp_data", 32'(rsp_data), 0);
      checkVal("rst_rsp_rd", 32'(rsp_rd), 0);
      checkVal("rst_state", 32'(dbgState), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int r = 0; r < 4; r++) readReg("rst_readback", r, 0);

      // 2: sra with shift amount taken from the rt index
      doLoad("ld_r0", 0, 4'b1000);
      doLoad("ld_r1", 1, 3);
      expQ.push_back(4'b1100);
      sendCmd(0, 0, 2, 0, 1, 0);
      checkVal("sra_alu_c", 32'(alu_c), 1);
      checkVal("sra_alu_a", 32'(alu_a), 4'b1000);
      checkVal("sra_alu_b", 32'(alu_b), 3);
      checkVal("sra_alu_op", 32'(alu_op), 0);
      checkVal("sra_exec_no_valid", 32'(rsp_valid), 0);
      checkVal("sra_exec_state", 32'(dbgState), 1);
      waitRsp("sra", 2, 2);
      consumeRsp("sra");

      // 3: srl, then sub with wraparound
      doAlu("srl", 1, 3, 0, 2, 4'b0010);
      doLoad("ld_r2", 2, 0);
      doAlu("sub_wrap", 2, 2, 2, 1, 4'b1101);
      readReg("rb_r3", 3, 4'b0010);

      // 4: add with wraparound to zero, destination equals source
      doLoad("ld_r0_15", 0, 15);
      doLoad("ld_r1_1", 1, 1);
      doAlu("add_wrap", 3, 0, 0, 1, 0);
      readReg("rb_r0", 0, 0);

      // 5: response stall; command pulse during the stall must be ignored
      expQ.push_back(4'd6);
      sendCmd(1, 0, 3, 0, 0, 6);
      waitRsp("stall", 3, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
         checkVal("stall_valid", 32'(rsp_valid), 1);
         checkVal("stall_data", 32'(rsp_data), 6);
         checkVal("stall_rd", 32'(rsp_rd), 3);
         checkVal("stall_cmd_ready", 32'(cmd_ready), 0);
         if (i == 2) begin
            cmd_ld    = 1'b1;
            cmd_rd    = 2'd3;
            cmd_imm   = 4'd9;
            cmd_valid = 1'b1;
         end
      end
      cmd_valid = 1'b0;
      consumeRsp("stall");
      readReg("rb_r3_stall", 3, 6);

      // 6: reset during EXEC aborts and clears the register file
      doLoad("ld_r0_5", 0, 5);
      sendCmd(0, 3, 1, 0, 0, 0);
      checkVal("abort_exec_state", 32'(dbgState), 1);
      rst_n = 1'b0;
      #2;
      checkVal("abort_state", 32'(dbgState), 0);
      checkVal("abort_rsp_valid", 32'(rsp_valid), 0);
      checkVal("abort_alu_a", 32'(alu_a), 0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkVal("abort_no_rsp", 32'(rsp_valid), 0);
      end
      for (int r = 0; r < 4; r++) readReg("abort_readback", r, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
